// File: rtl/text_ram_arbiter.sv
// Arbitrates one single-port text RAM between display fetch, host port and a clear-screen fill engine.
// Display reads always win and return data exactly two edges after the request edge.
module text_ram_arbiter #(
    parameter int ADDR_BITS = 12,
    parameter int DATA_BITS = 16,
    parameter int FILL_LAST = 1999
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 disp_req_i,
    input  logic [ADDR_BITS-1:0] disp_addr_i,
    output logic [DATA_BITS-1:0] disp_data_o,
    output logic                 disp_valid_o,
    input  logic                 host_req_i,
    input  logic                 host_we_i,
    input  logic [ADDR_BITS-1:0] host_addr_i,
    input  logic [DATA_BITS-1:0] host_wdata_i,
    input  logic [1:0]           host_be_i,
    output logic                 host_ack_o,
    output logic [DATA_BITS-1:0] host_rdata_o,
    output logic                 host_rvalid_o,
    input  logic                 fill_start_i,
    input  logic [DATA_BITS-1:0] fill_value_i,
    output logic                 fill_busy_o,
    output logic [ADDR_BITS-1:0] ram_addr_o,
    output logic                 ram_we_o,
    output logic [1:0]           ram_be_o,
    output logic [DATA_BITS-1:0] ram_wdata_o,
    input  logic [DATA_BITS-1:0] ram_rdata_i
);

    typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_DISP = 2'd1, TAG_HOST = 2'd2} tag_e;
    typedef enum logic {ST_IDLE = 1'b0, ST_FILL = 1'b1} fill_state_e;

    localparam logic [ADDR_BITS-1:0] FILL_LAST_A = ADDR_BITS'(FILL_LAST);

    fill_state_e          state_q, state_d;
    logic [ADDR_BITS-1:0] fill_ptr_q, fill_ptr_d;
    logic [DATA_BITS-1:0] fill_value_q, fill_value_d;
    logic                 fill_write;

    logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
    logic                 ram_we_q, ram_we_d;
    logic [1:0]           ram_be_q, ram_be_d;
    logic [DATA_BITS-1:0] ram_wdata_q, ram_wdata_d;

    tag_e                 tag1_q, tag2_q, tag_d;
    logic [DATA_BITS-1:0] disp_data_q, host_rdata_q;
    logic                 disp_valid_q, host_rvalid_q;

    // Display can never be stalled, so the host only sees an accept when display is quiet.
    assign host_ack_o = host_req_i & ~disp_req_i & ~reset_i;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latches).
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_be_d    = ram_be_q;
        ram_wdata_d = ram_wdata_q;
        tag_d       = TAG_NONE;
        fill_write  = 1'b0;
        if (disp_req_i) begin
            ram_addr_d = disp_addr_i;
            ram_be_d   = 2'b11;
            tag_d      = TAG_DISP;
        end else if (host_req_i) begin
            ram_addr_d = host_addr_i;
            if (host_we_i) begin
                ram_we_d    = 1'b1;
                ram_be_d    = host_be_i;
                ram_wdata_d = host_wdata_i;
            end else begin
                ram_be_d = 2'b11;
                tag_d    = TAG_HOST;
            end
        end else if (state_q == ST_FILL) begin
            ram_addr_d  = fill_ptr_q;
            ram_we_d    = 1'b1;
            ram_be_d    = 2'b11;
            ram_wdata_d = fill_value_q;
            fill_write  = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        fill_ptr_d   = fill_ptr_q;
        fill_value_d = fill_value_q;
        case (state_q)
            ST_IDLE: begin
                if (fill_start_i) begin
                    state_d      = ST_FILL;
                    fill_ptr_d   = '0;
                    fill_value_d = fill_value_i;
                end
            end
            ST_FILL: begin
                // The pointer parks on the last cell, so it never leaves the screen area.
                if (fill_write) begin
                    if (fill_ptr_q == FILL_LAST_A) state_d = ST_IDLE;
                    else                           fill_ptr_d = fill_ptr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            fill_ptr_q    <= '0;
            fill_value_q  <= '0;
            ram_addr_q    <= '0;
            ram_we_q      <= 1'b0;
            ram_be_q      <= 2'b00;
            ram_wdata_q   <= '0;
            tag1_q        <= TAG_NONE;
            tag2_q        <= TAG_NONE;
            disp_data_q   <= '0;
            disp_valid_q  <= 1'b0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fill_ptr_q    <= fill_ptr_d;
            fill_value_q  <= fill_value_d;
            ram_addr_q    <= ram_addr_d;
            ram_we_q      <= ram_we_d;
            ram_be_q      <= ram_be_d;
            ram_wdata_q   <= ram_wdata_d;
            tag1_q        <= tag_d;
            tag2_q        <= tag1_q;
            disp_valid_q  <= (tag2_q == TAG_DISP);
            host_rvalid_q <= (tag2_q == TAG_HOST);
            // Tag reaches stage two exactly when the RAM presents the matching word.
            if (tag2_q == TAG_DISP) disp_data_q  <= ram_rdata_i;
            if (tag2_q == TAG_HOST) host_rdata_q <= ram_rdata_i;
        end
    end

    assign disp_data_o   = disp_data_q;
    assign disp_valid_o  = disp_valid_q;
    assign host_rdata_o  = host_rdata_q;
    assign host_rvalid_o = host_rvalid_q;
    assign fill_busy_o   = (state_q == ST_FILL);
    assign ram_addr_o    = ram_addr_q;
    assign ram_we_o      = ram_we_q;
    assign ram_be_o      = ram_be_q;
    assign ram_wdata_o   = ram_wdata_q;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Scoreboard bench for text_ram_arbiter: a transaction-level model predicts every RAM command,
// read response and accept, and a monitor compares them against the DUT each cycle.
module tb_text_ram_arbiter;
    localparam int AB = 12;
    localparam int DB = 16;
    localparam int FL = 1999;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic          disp_req_i;
    logic [AB-1:0] disp_addr_i;
    logic [DB-1:0] disp_data_o;
    logic          disp_valid_o;
    logic          host_req_i;
    logic          host_we_i;
    logic [AB-1:0] host_addr_i;
    logic [DB-1:0] host_wdata_i;
    logic [1:0]    host_be_i;
    logic          host_ack_o;
    logic [DB-1:0] host_rdata_o;
    logic          host_rvalid_o;
    logic          fill_start_i;
    logic [DB-1:0] fill_value_i;
    logic          fill_busy_o;
    logic [AB-1:0] ram_addr_o;
    logic          ram_we_o;
    logic [1:0]    ram_be_o;
    logic [DB-1:0] ram_wdata_o;
    logic [DB-1:0] ram_rdata_i;

    text_ram_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .FILL_LAST(FL)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i),
        .disp_data_o(disp_data_o), .disp_valid_o(disp_valid_o),
        .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
        .host_wdata_i(host_wdata_i), .host_be_i(host_be_i), .host_ack_o(host_ack_o),
        .host_rdata_o(host_rdata_o), .host_rvalid_o(host_rvalid_o),
        .fill_start_i(fill_start_i), .fill_value_i(fill_value_i), .fill_busy_o(fill_busy_o),
        .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        int            edge_n;
        logic          we;
        logic [AB-1:0] addr;
        logic [1:0]    be;
        logic [DB-1:0] wdata;
        logic          busy;
    } cmd_t;

    typedef struct {
        int            edge_n;
        logic [DB-1:0] data;
    } rd_t;

    cmd_t cmd_q[$];
    rd_t  disp_q[$];
    rd_t  host_q[$];

    logic [DB-1:0] ram_mem [0:4095];
    logic [DB-1:0] ref_mem [0:4095];

    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   we_seen  = 0;
    logic exp_ack_now = 1'b0;

    // Reference model state: transaction-level view of the arbiter.
    bit            m_fill = 1'b0;
    int            m_ptr  = 0;
    logic [DB-1:0] m_fval = '0;
    logic [AB-1:0] m_addr = '0;
    logic [1:0]    m_be   = '0;
    logic [DB-1:0] m_wdata = '0;

    // Synchronous single-port RAM with byte enables, one-cycle read latency.
    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram_mem[i] = 16'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        ram_mem[12'h010] = 16'h0730;
        ref_mem[12'h010] = 16'h0730;
        forever begin
            @(posedge clock_i);
            if (ram_we_o === 1'b1) begin
                if (ram_be_o[1]) ram_mem[ram_addr_o][15:8] <= ram_wdata_o[15:8];
                if (ram_be_o[0]) ram_mem[ram_addr_o][7:0]  <= ram_wdata_o[7:0];
            end
            ram_rdata_i <= ram_mem[ram_addr_o];
        end
    end

    initial forever begin
        @(posedge clock_i);
        edge_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Drive one cycle of inputs, advance the model for the coming edge, then step past that edge.
    task automatic drive(input bit rst, input bit dreq, input logic [AB-1:0] daddr,
                         input bit hreq, input bit hwe, input logic [AB-1:0] haddr,
                         input logic [DB-1:0] hwd, input logic [1:0] hbe,
                         input bit fstart, input logic [DB-1:0] fval);
        int   e;
        bit   fill_pre;
        cmd_t c;
        rd_t  r;
        reset_i = rst; disp_req_i = dreq; disp_addr_i = daddr;
        host_req_i = hreq; host_we_i = hwe; host_addr_i = haddr;
        host_wdata_i = hwd; host_be_i = hbe;
        fill_start_i = fstart; fill_value_i = fval;
        e = edge_cnt + 1;
        exp_ack_now = hreq && !dreq && !rst;
        fill_pre = m_fill;
        c.we = 1'b0;
        if (rst) begin
            m_fill = 1'b0; m_ptr = 0;
            m_addr = '0; m_be = '0; m_wdata = '0;
            while (disp_q.size() > 0 && disp_q[$].edge_n >= e) void'(disp_q.pop_back());
            while (host_q.size() > 0 && host_q[$].edge_n >= e) void'(host_q.pop_back());
        end else begin
            if (dreq) begin
                m_addr = daddr; m_be = 2'b11;
                r.edge_n = e + 2; r.data = ref_mem[daddr];
                disp_q.push_back(r);
            end else if (hreq) begin
                m_addr = haddr;
                if (hwe) begin
                    c.we = 1'b1; m_be = hbe; m_wdata = hwd;
                    if (hbe[1]) ref_mem[haddr][15:8] = hwd[15:8];
                    if (hbe[0]) ref_mem[haddr][7:0]  = hwd[7:0];
                end else begin
                    m_be = 2'b11;
                    r.edge_n = e + 2; r.data = ref_mem[haddr];
                    host_q.push_back(r);
                end
            end else if (m_fill) begin
                c.we = 1'b1; m_addr = 12'(m_ptr); m_be = 2'b11; m_wdata = m_fval;
                ref_mem[m_ptr] = m_fval;
                if (m_ptr == FL) m_fill = 1'b0;
                else             m_ptr++;
            end
            if (!fill_pre && fstart) begin
                m_fill = 1'b1; m_ptr = 0; m_fval = fval;
            end
        end
        c.edge_n = e; c.addr = m_addr; c.be = m_be; c.wdata = m_wdata; c.busy = m_fill;
        cmd_q.push_back(c);
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0, 0, 0, '0, '0, '0, 0, '0);
    endtask

    // Monitor: compares the DUT against the scoreboard on each falling edge.
    initial begin : monitor
        cmd_t c;
        rd_t  r;
        forever begin
            @(negedge clock_i);
            if (ram_we_o === 1'b1) we_seen++;
            check("host_ack", 32'(host_ack_o), 32'(exp_ack_now));
            if (cmd_q.size() > 0 && cmd_q[0].edge_n == edge_cnt) begin
                c = cmd_q.pop_front();
                check("ram_we", 32'(ram_we_o), 32'(c.we));
                check("ram_addr", 32'(ram_addr_o), 32'(c.addr));
                check("ram_be", 32'(ram_be_o), 32'(c.be));
                check("ram_wdata", 32'(ram_wdata_o), 32'(c.wdata));
                check("fill_busy", 32'(fill_busy_o), 32'(c.busy));
            end
            if (disp_valid_o === 1'b1) begin
                if (disp_q.size() == 0) check("disp_unexpected", 32'(disp_valid_o), 32'd0);
                else begin
                    r = disp_q.pop_front();
                    check("disp_edge", edge_cnt, r.edge_n);
                    check("disp_data", 32'(disp_data_o), 32'(r.data));
                end
            end else if (disp_q.size() > 0 && disp_q[0].edge_n <= edge_cnt) begin
                r = disp_q.pop_front();
                check("disp_missing", 32'(disp_valid_o), 32'd1);
            end
            if (host_rvalid_o === 1'b1) begin
                if (host_q.size() == 0) check("host_unexpected", 32'(host_rvalid_o), 32'd0);
                else begin
                    r = host_q.pop_front();
                    check("host_edge", edge_cnt, r.edge_n);
                    check("host_data", 32'(host_rdata_o), 32'(r.data));
                end
            end else if (host_q.size() > 0 && host_q[0].edge_n <= edge_cnt) begin
                r = host_q.pop_front();
                check("host_missing", 32'(host_rvalid_o), 32'd1);
            end
        end
    end

    initial begin : stimulus
        int  w0;
        bit  pend;
        bit  p_we;
        logic [AB-1:0] p_addr;
        logic [DB-1:0] p_wd;
        logic [1:0]    p_be;
        bit  dreq;

        // Reset state.
        drive(1, 0, '0, 0, 0, '0, '0, '0, 0, '0);
        drive(1, 0, '0, 0, 0, '0, '0, '0, 0, '0);
        drive(1, 0, '0, 0, 0, '0, '0, '0, 0, '0);
        check("disp_data_rst", 32'(disp_data_o), 32'd0);
        check("host_rdata_rst", 32'(host_rdata_o), 32'd0);
        check("disp_valid_rst", 32'(disp_valid_o), 32'd0);

        // Display-only read of a known word.
        drive(0, 1, 12'h010, 0, 0, '0, '0, '0, 0, '0);
        idle(3);

        // Contention: display wins three cycles, then the held host read is accepted.
        for (int i = 0; i < 3; i++)
            drive(0, 1, 12'(16 * i + 3), 1, 0, 12'h020, '0, '0, 0, '0);
        drive(0, 0, '0, 1, 0, 12'h020, '0, '0, 0, '0);
        idle(3);

        // Host write of the character byte only, then read it back.
        drive(0, 0, '0, 1, 1, 12'h005, 16'h1F41, 2'b01, 0, '0);
        drive(0, 0, '0, 1, 0, 12'h005, '0, '0, 0, '0);
        idle(3);

        // Full fill with no other traffic; a second start mid-fill must be ignored.
        drive(0, 0, '0, 0, 0, '0, '0, '0, 1, 16'h0720);
        w0 = we_seen;
        idle(1000);
        drive(0, 0, '0, 0, 0, '0, '0, '0, 1, 16'hBEEF);
        idle(1002);
        check("fill_write_count", we_seen - w0, 2000);
        check("fill_busy_done", 32'(fill_busy_o), 32'd0);
        drive(0, 1, 12'd0, 0, 0, '0, '0, '0, 0, '0);
        drive(0, 1, 12'd1999, 0, 0, '0, '0, '0, 0, '0);
        drive(0, 0, '0, 1, 0, 12'd2000, '0, '0, 0, '0);
        idle(3);

        // Fill interleaved with display reads every other cycle: 4000 cycles to complete.
        drive(0, 0, '0, 0, 0, '0, '0, '0, 1, 16'h1234);
        for (int i = 0; i < 4000; i++) begin
            dreq = (i % 2 == 0);
            drive(0, dreq, 12'($urandom_range(0, 1999)), 0, 0, '0, '0, '0, 0, '0);
        end
        check("interleaved_fill_done", 32'(fill_busy_o), 32'd0);
        idle(3);

        // Randomised mix; the host request is held until accepted.
        pend = 1'b0; p_we = 1'b0; p_addr = '0; p_wd = '0; p_be = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend && ($urandom_range(0, 1) == 1)) begin
                pend = 1'b1; p_we = 1'($urandom); p_addr = 12'($urandom);
                p_wd = 16'($urandom); p_be = 2'($urandom);
            end
            dreq = ($urandom_range(0, 2) == 0);
            drive(0, dreq, 12'($urandom), pend, p_we, p_addr, p_wd, p_be,
                  ($urandom_range(0, 499) == 0), 16'($urandom));
            if (pend && !dreq) pend = 1'b0;
        end
        idle(2100);

        // Reset during a fill, one cycle after a host read accept.
        drive(0, 0, '0, 0, 0, '0, '0, '0, 1, 16'h5A5A);
        idle(10);
        drive(0, 0, '0, 1, 0, 12'h123, '0, '0, 0, '0);
        drive(1, 0, '0, 0, 0, '0, '0, '0, 0, '0);
        check("busy_after_reset", 32'(fill_busy_o), 32'd0);
        check("we_after_reset", 32'(ram_we_o), 32'd0);
        idle(3);
        drive(0, 0, '0, 0, 0, '0, '0, '0, 1, 16'h0F0F);
        idle(6);
        drive(1, 0, '0, 0, 0, '0, '0, '0, 0, '0);
        idle(4);

        check("disp_queue_drained", disp_q.size(), 0);
        check("host_queue_drained", host_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/text_ram_arbiter.md
Name: text_ram_arbiter

Overview:
- Shares the single-port 16-bit text RAM (attr[15:8], char[7:0]) between three requesters:
  - the text-mode display fetch path;
  - a host read/write port;
  - an internal clear-screen fill engine.
- Sits between the text-mode renderer's address/data fetch interface and the synchronous text RAM.
- Guarantees fixed-latency display reads so character timing is never disturbed.

Parameters:
- ADDR_BITS, 12, text RAM address width.
- DATA_BITS, 16, text RAM word width (attribute:character).
- FILL_LAST, 1999, last address written by a fill (80x25 cells, 0..1999).

Ports:
- clock_i  in  1  system clock (dot clock domain).
- reset_i  in  1  synchronous, active-high reset.
- disp_req_i  in  1  display fetch request this cycle.
- disp_addr_i  in  ADDR_BITS  display fetch address.
- disp_data_o  out  DATA_BITS  display read data.
- disp_valid_o  out  1  one-cycle pulse, disp_data_o valid.
- host_req_i  in  1  host request; held until accepted.
- host_we_i  in  1  1 = write, 0 = read.
- host_addr_i  in  ADDR_BITS  host address.
- host_wdata_i  in  DATA_BITS  host write data.
- host_be_i  in  2  host byte enables (bit1 = attr, bit0 = char).
- host_ack_o  out  1  combinational accept; transfer occurs when host_req_i & host_ack_o at a rising edge.
- host_rdata_o  out  DATA_BITS  host read data.
- host_rvalid_o  out  1  one-cycle pulse, host_rdata_o valid.
- fill_start_i  in  1  start clear-screen fill.
- fill_value_i  in  DATA_BITS  fill word, sampled on accepted start.
- fill_busy_o  out  1  fill in progress.
- ram_addr_o  out  ADDR_BITS  RAM address (registered).
- ram_we_o  out  1  RAM write enable (registered).
- ram_be_o  out  2  RAM byte enables (registered).
- ram_wdata_o  out  DATA_BITS  RAM write data (registered).
- ram_rdata_i  in  DATA_BITS  RAM read data; valid one cycle after the registered command.

Behaviour:
- Fixed priority, evaluated each cycle: display > host > fill. One RAM command per cycle, registered onto ram_* at the rising edge.
- host_ack_o = host_req_i & ~disp_req_i. A display request always wins and is never stalled.
- Command encoding:
  - Display read: ram_we_o=0, ram_be_o=11.
  - Host read: ram_we_o=0, ram_be_o=11.
  - Host write: ram_we_o=1, ram_be_o=host_be_i, ram_wdata_o=host_wdata_i.
  - Fill write: ram_we_o=1, ram_be_o=11, ram_wdata_o=latched fill value.
- Idle cycle: ram_we_o=0; ram_addr_o, ram_be_o and ram_wdata_o hold their previous values.
- Read latency:
  - Request sampled at edge k; ram_* valid after edge k; ram_rdata_i valid after edge k+1.
  - Data is registered into disp_data_o or host_rdata_o at edge k+2, with a one-cycle valid pulse.
  - Achieved with a 2-stage tag pipeline (NONE/DISP/HOST).
- Host writes produce no response beyond the accept.
- Back-to-back requests are sustained at one per cycle; reads and writes may interleave freely.
- Data outputs hold their last value when the corresponding valid is low.
- Fill FSM states: IDLE, FILL.
  - IDLE -> FILL on fill_start_i: latch fill_value_i, fill_ptr=0.
  - In FILL, each cycle with no display and no host request: write latched value to fill_ptr, then fill_ptr+1.
  - After the write to FILL_LAST is registered: -> IDLE.
  - fill_busy_o is high from the edge after start acceptance to the edge after the last fill write.
- fill_start_i while busy is ignored; the fill is neither restarted nor re-latched.
- fill_start_i in the same cycle as a display or host request: start is still accepted. The first fill write waits for a free slot.
- Host writes during a fill are not protected: a host write to an address not yet filled is overwritten.
- Address range is not checked: addresses pass through unchanged, and fill_ptr never exceeds FILL_LAST.
- Reset:
  - All outputs 0; FSM to IDLE; fill_ptr 0; tag pipeline cleared.
  - Reads in flight are dropped (no valid pulse).
  - Reset during a fill aborts it.

Test Plan:
- Display-only read: disp_req_i=1, addr 0x010 at edge k, RAM returns 0x0730 -> ram_addr_o=0x010 after k; disp_valid_o pulse with disp_data_o=0x0730 after k+2.
- Contention: disp_req_i and host_req_i (read 0x020) both high for 3 cycles, then disp low -> host_ack_o=0 for 3 cycles, then 1; host_rvalid_o arrives 2 cycles after the accept edge; all 3 disp_valid_o pulses on time.
- Host write with byte enables: write 0x1F41 to 0x005 with be=01 -> ram_we_o=1, ram_be_o=01, ram_wdata_o=0x1F41 for one cycle; no host_rvalid_o.
- Full fill: fill_start_i with value 0x0720, no other traffic -> exactly 2000 writes to addresses 0..1999 in 2000 consecutive cycles; fill_busy_o drops after the last write; a second start mid-fill is ignored.
- Fill interleaved with display at 1 request per 2 cycles -> fill completes in 4000 cycles, with no display read delayed or lost.
- Reset mid-operation: assert reset_i one cycle after a host read accept and during a fill -> no host_rvalid_o, fill_busy_o=0, ram_we_o=0 the cycle after reset; a new fill afterwards restarts at address 0.
